soc_event_bus_tx: RTL
=====================

# soc_event_bus_tx

Multi-channel event sender for the SoC-to-cluster event bus. It collects single-cycle event pulses from `NB_CHANNELS` SoC sources and counts them per channel, saturating. It arbitrates round-robin between channels and writes one event ID per transfer into a `BUFFER_DEPTH`-slot ring buffer. The cluster-side reader, which is in another clock domain, sees the ring through a one-hot write token and returns a one-hot read pointer. The block generalises the fixed 8-slot, 8-bit cluster event bus with:
- parametrised depth, width and channel count;
- per-channel loss-free pending counters;
- sticky overflow flags.

## Interface
Parameters:
- `NB_CHANNELS`, 8, number of event sources (≥2)
- `EVNT_WIDTH`, 8, event ID width
- `BUFFER_DEPTH`, 8, ring slots (≥2); also the width of the token and the pointer
- `CNT_WIDTH`, 4, width of each per-channel pending counter
- `EVT_ID_BASE`, 0, ID sent for channel c is `(EVT_ID_BASE + c)` truncated to `EVNT_WIDTH`

Ports:
- `clk_i` in 1: the single clock
- `rst_ni` in 1: reset, asynchronous and active-low
- `evt_i` in `NB_CHANNELS`: one-cycle event pulse per channel
- `ovf_clr_i` in `NB_CHANNELS`: clears the matching sticky overflow flag
- `events_wt_o` out `BUFFER_DEPTH`: one-hot write token to the reader
- `events_rp_i` in `BUFFER_DEPTH`: one-hot read pointer from the reader (asynchronous)
- `events_da_o` out `BUFFER_DEPTH*EVNT_WIDTH`: ring slot contents; slot k is at bits `[k*EVNT_WIDTH +: EVNT_WIDTH]`
- `evt_overflow_o` out `NB_CHANNELS`: sticky flag, at least one event lost
- `busy_o` out 1: high while any counter is non-zero or the FSM is in COMMIT

## Operation
- **Read-pointer sync**: `events_rp_i` passes through a 2-flop synchronizer, giving `rp_sync`. `rp_sync` resets to one-hot bit 0.
- **Full**: `rotl(events_wt_o) == rp_sync`. One slot is always left unused, so at most `BUFFER_DEPTH-1` events are outstanding. Full is conservative: the reader's pointer is seen 2 cycles late.
- **Pending counters** (one per channel, updated every cycle):
  - pulse only: +1
  - dispatch only: −1
  - pulse and dispatch together: unchanged
  - at 2^CNT_WIDTH−1 with a pulse and no dispatch: holds, and `evt_overflow_o[c]` sets
  - at max with pulse and dispatch together: stays at max, no overflow
- **Overflow flags**: `ovf_clr_i[c]` clears `evt_overflow_o[c]`. If a clear and a new overflow happen in the same cycle, set wins.
- **Arbiter**: round-robin over channels whose counter is non-zero.
  - The priority pointer starts at 0.
  - After granting channel c, the pointer becomes (c+1) mod `NB_CHANNELS`.
- **FSM, two states**:
  - IDLE: if any counter is non-zero and the ring is not full, then at the edge:
    - write the granted channel's ID into the slot selected by `events_wt_o`;
    - decrement that channel's counter;
    - advance the priority pointer;
    - go to COMMIT.
    Otherwise stay in IDLE.
  - COMMIT: rotate `events_wt_o` left by one (bit `BUFFER_DEPTH-1` wraps to bit 0), go to IDLE.
  - The token never changes in the same cycle as slot data, so data is stable at least one cycle before the reader can observe the token.
- **Reset values**: all outputs, counters and flags are 0, except `events_wt_o` = one-hot bit 0. FSM = IDLE, priority pointer = 0.
- **Reset mid-operation** (including during COMMIT): all state clears immediately and pending events are dropped. The reader must be reset at the same time.

## Timing
- Pulse in cycle 0 → counter updated at edge 1 → slot written at edge 2 → token rotates at edge 3.
- Peak throughput is one event per 2 cycles.
- The reader freeing a slot (`events_rp_i` rotates) becomes visible in `rp_sync` after 2 edges; a stalled IDLE can dispatch on the next edge after that.
- Slots that are not being written hold their value; slot data is never cleared except by reset.
- `evt_overflow_o` and the counters change at the edge after the pulse.

## Test plan
- Single event: `EVT_ID_BASE`=0x10, pulse on `evt_i[3]` at cycle 0 with an empty ring → at edge 2 slot 0 = 0x13; at edge 3 `events_wt_o` goes 0x01→0x02; `busy_o` goes low after edge 3.
- Full ring: `events_rp_i` held at 0x01, one pulse on each of channels 0–7 → 7 slots written, `events_wt_o` = 0x80, channel 7's counter stays at 1. Then set `events_rp_i` = 0x02 → the 8th event is written into slot 7 within 4 cycles, and the token wraps to 0x01.
- Round robin: channels 0 and 5 each pulsed twice in the same cycles → dispatch order 0, 5, 0, 5.
- Saturation: `CNT_WIDTH`=2, ring full, 4 pulses on channel 1 → counter = 3, `evt_overflow_o[1]`=1. Pulse `ovf_clr_i[1]` → flag 0, counter still 3.
- Simultaneous update: channel 2's counter at 3 (max), a pulse in the same cycle it is dispatched → counter stays 3, no overflow.
- Reset mid-COMMIT: assert `rst_ni`=0 in the COMMIT cycle → outputs immediately return to reset values (`events_wt_o` = 0x01, counters 0, flags 0); after release, a new pulse is written to slot 0.

Source files
------------

// File: rtl/soc_event_bus_tx.sv
// soc_event_bus_tx
// Multi-channel event sender for the SoC-to-cluster event bus. Event pulses
// from NB_CHANNELS sources are counted per channel (saturating), arbitrated
// round-robin and written one ID per transfer into a BUFFER_DEPTH-slot ring.
// The cluster-side reader, in another clock domain, sees the ring through a
// one-hot write token and returns a one-hot read pointer.
//
// Handshake: a slot is written in IDLE and the token rotates one cycle later
// in COMMIT, so slot data is always stable before the reader can see the
// token move past it. The reader owns every slot from its read pointer up to
// (not including) the token. The slot just behind the read pointer is never
// written, which is how full and empty are told apart.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   evt_i            one-cycle event pulse per channel
//   ovf_clr_i        clears the matching sticky overflow flag
//   events_wt_o      one-hot write token to the reader
//   events_rp_i      one-hot read pointer from the reader (asynchronous)
//   events_da_o      ring contents, slot k at [k*EVNT_WIDTH +: EVNT_WIDTH]
//   evt_overflow_o   sticky flag per channel, at least one event lost
//   busy_o           any counter non-zero or a commit in progress
module soc_event_bus_tx #(
  parameter int unsigned NB_CHANNELS  = 8,
  parameter int unsigned EVNT_WIDTH   = 8,
  parameter int unsigned BUFFER_DEPTH = 8,
  parameter int unsigned CNT_WIDTH    = 4,
  parameter int unsigned EVT_ID_BASE  = 0
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NB_CHANNELS-1:0]             evt_i,
  input  logic [NB_CHANNELS-1:0]             ovf_clr_i,
  output logic [BUFFER_DEPTH-1:0]            events_wt_o,
  input  logic [BUFFER_DEPTH-1:0]            events_rp_i,
  output logic [BUFFER_DEPTH*EVNT_WIDTH-1:0] events_da_o,
  output logic [NB_CHANNELS-1:0]             evt_overflow_o,
  output logic                               busy_o
);

  localparam int unsigned PW = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {S_IDLE, S_COMMIT} state_e;

  state_e                            state_q, state_d;
  logic [BUFFER_DEPTH-1:0]           rp_meta_q, rp_sync_q;
  logic [BUFFER_DEPTH-1:0]           wt_q, wt_d, wt_rotl;
  logic [BUFFER_DEPTH*EVNT_WIDTH-1:0] da_q, da_d;
  logic [CNT_WIDTH-1:0]              cnt_q [NB_CHANNELS];
  logic [CNT_WIDTH-1:0]              cnt_d [NB_CHANNELS];
  logic [NB_CHANNELS-1:0]            ovf_q, ovf_d, ovf_set;
  logic [NB_CHANNELS-1:0]            nz;
  logic [PW-1:0]                     prio_q, prio_d, gnt_idx;
  logic                              gnt_valid, full, dispatch;
  logic [EVNT_WIDTH-1:0]             evt_id;
  int unsigned                       scan_idx;

  // Full compares against the synchronised pointer, which lags the reader by
  // two cycles, so it can only over-report fullness.
  assign wt_rotl = {wt_q[BUFFER_DEPTH-2:0], wt_q[BUFFER_DEPTH-1]};
  assign full    = (wt_rotl == rp_sync_q);

  always_comb begin
    for (int c = 0; c < NB_CHANNELS; c++) nz[c] = (cnt_q[c] != '0);
  end

  // Round-robin: first non-zero channel at or after the priority pointer.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int i = 0; i < NB_CHANNELS; i++) begin
      scan_idx = 32'(prio_q) + 32'(i);
      if (scan_idx >= NB_CHANNELS) scan_idx = scan_idx - NB_CHANNELS;
      if (!gnt_valid && nz[scan_idx[PW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan_idx[PW-1:0];
      end
    end
  end

  assign dispatch = (state_q == S_IDLE) && gnt_valid && !full;
  assign evt_id   = EVNT_WIDTH'(EVT_ID_BASE + 32'(gnt_idx));

  // FSM next state, token and slot data.
  always_comb begin
    state_d = state_q;
    wt_d    = wt_q;
    da_d    = da_q;
    prio_d  = prio_q;
    case (state_q)
      S_IDLE: begin
        if (dispatch) begin
          for (int k = 0; k < BUFFER_DEPTH; k++) begin
            if (wt_q[k]) da_d[k*EVNT_WIDTH +: EVNT_WIDTH] = evt_id;
          end
          prio_d  = (gnt_idx == PW'(NB_CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        wt_d    = wt_rotl;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending counters: a pulse and a dispatch together cancel, which also
  // keeps a saturated counter at max without flagging a loss.
  always_comb begin
    ovf_set = '0;
    for (int c = 0; c < NB_CHANNELS; c++) begin
      cnt_d[c] = cnt_q[c];
      if (evt_i[c] && !(dispatch && gnt_idx == PW'(c))) begin
        if (cnt_q[c] == CNT_MAX) ovf_set[c] = 1'b1;
        else                     cnt_d[c]   = cnt_q[c] + 1'b1;
      end else if (!evt_i[c] && dispatch && gnt_idx == PW'(c)) begin
        cnt_d[c] = cnt_q[c] - 1'b1;
      end
    end
    ovf_d = (ovf_q & ~ovf_clr_i) | ovf_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      rp_meta_q <= BUFFER_DEPTH'(1);
      rp_sync_q <= BUFFER_DEPTH'(1);
      wt_q      <= BUFFER_DEPTH'(1);
      da_q      <= '0;
      ovf_q     <= '0;
      prio_q    <= '0;
      for (int c = 0; c < NB_CHANNELS; c++) cnt_q[c] <= '0;
    end else begin
      state_q   <= state_d;
      rp_meta_q <= events_rp_i;
      rp_sync_q <= rp_meta_q;
      wt_q      <= wt_d;
      da_q      <= da_d;
      ovf_q     <= ovf_d;
      prio_q    <= prio_d;
      for (int c = 0; c < NB_CHANNELS; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign events_wt_o    = wt_q;
  assign events_da_o    = da_q;
  assign evt_overflow_o = ovf_q;
  assign busy_o         = (|nz) || (state_q == S_COMMIT);

endmodule
